// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern generator: pattern mode
// encodings, a bit-replication helper and the colour-bar index function.
package vga_pkg;

    localparam logic [2:0] MODE_HSTRIPE = 3'd0;
    localparam logic [2:0] MODE_VSTRIPE = 3'd1;
    localparam logic [2:0] MODE_CHECKER = 3'd2;
    localparam logic [2:0] MODE_BARS    = 3'd3;
    localparam logic [2:0] MODE_SCROLL  = 3'd4;
    localparam logic [2:0] MODE_SOLID   = 3'd5;

    // Widest colour channel the replication helper supports; callers
    // size-cast the result down to their own channel width.
    localparam int REP_MAX_W = 16;

    function automatic logic [REP_MAX_W-1:0] rep(input logic b);
        return {REP_MAX_W{b}};
    endfunction

    // Colour-bar number 0..7 for a pixel column; saturates at 7 beyond the
    // active width so blanking-region columns still map to a legal bar.
    function automatic logic [2:0] bar_index(input int unsigned hc,
                                             input int unsigned h_active);
        logic [2:0] idx;
        idx = 3'd0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (hc >= (k * h_active) / 8) begin
                idx = 3'(k);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Video bus between the sync counter, the pattern generator and the colour
// mux: pixel coordinates/enable in, registered RGB and enable out.
interface vga_pattern_gen_if #(
    parameter int COLOR_W = 4,
    parameter int COORD_W = 11
);
    logic               vidon;
    logic [COORD_W-1:0] hc;
    logic [COORD_W-1:0] vc;
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
    logic               vidon_o;

    modport master (
        output vidon, hc, vc,
        input  red, green, blue, vidon_o
    );

    modport slave (
        input  vidon, hc, vc,
        output red, green, blue, vidon_o
    );
endinterface

// File: rtl/vga_frame_timer.sv
// Frame-start detection and scroll offset generation. A frame starts when
// vc returns to 0 from a non-zero line; every SCROLL_DIV unpaused frames the
// scroll offset advances by one line, wrapping silently.
module vga_frame_timer #(
    parameter int COORD_W    = 11,
    parameter int SCROLL_DIV = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] vc,
    input  logic               pause,
    output logic               tick,
    output logic               frame_tick,
    output logic [COORD_W-1:0] offset
);
    localparam int DIV_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCROLL_DIV - 1);

    logic [COORD_W-1:0] vc_d;
    logic [DIV_W-1:0]   div_cnt;

    // vc_d resets to 0 so a vc held at 0 across reset release cannot tick.
    assign tick = (vc == '0) && (vc_d != '0);

    // Remember the previous line and publish the registered frame pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            vc_d       <= '0;
            frame_tick <= 1'b0;
        end else begin
            vc_d       <= vc;
            frame_tick <= tick;
        end
    end

    // Frame divider and scroll offset; pause freezes both.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            offset  <= '0;
        end else if (tick && !pause) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                offset  <= offset + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// Registered VGA test-pattern generator. Mode and solid colour are latched
// only at frame start so a pattern never changes mid-frame; RGB and the
// delayed video enable appear one clock after the coordinates.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int          COLOR_W     = 4,
    parameter int          COORD_W     = 11,
    parameter int          STRIPE_LOG2 = 4,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int          SCROLL_DIV  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    vga_pattern_gen_if.slave       vid,
    input  logic [2:0]             mode,
    input  logic                   pause,
    input  logic [3*COLOR_W-1:0]   solid_rgb,
    output logic                   frame_tick
);
    logic                   tick;
    logic [COORD_W-1:0]     offset;
    logic [COORD_W-1:0]     scroll_vc;
    logic [2:0]             mode_q;
    logic [3*COLOR_W-1:0]   solid_q;
    logic [2:0]             bar;
    logic [COLOR_W-1:0]     red_n;
    logic [COLOR_W-1:0]     green_n;
    logic [COLOR_W-1:0]     blue_n;

    vga_frame_timer #(
        .COORD_W    (COORD_W),
        .SCROLL_DIV (SCROLL_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .vc         (vid.vc),
        .pause      (pause),
        .tick       (tick),
        .frame_tick (frame_tick),
        .offset     (offset)
    );

    assign scroll_vc = vid.vc + offset;
    assign bar       = bar_index(32'(vid.hc), H_ACTIVE);

    // Latch the requested pattern and solid colour at frame start only.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= '0;
            solid_q <= '0;
        end else if (tick) begin
            mode_q  <= mode;
            solid_q <= solid_rgb;
        end
    end

    // Select the pixel colour for the current coordinate; blank outside video.
    always_comb begin
        red_n   = '0;
        green_n = '0;
        blue_n  = '0;
        if (vid.vidon) begin
            case (mode_q)
                MODE_HSTRIPE: begin
                    red_n   = COLOR_W'(rep(vid.vc[STRIPE_LOG2]));
                    green_n = COLOR_W'(rep(!vid.vc[STRIPE_LOG2]));
                end
                MODE_VSTRIPE: begin
                    red_n   = COLOR_W'(rep(vid.hc[STRIPE_LOG2]));
                    green_n = COLOR_W'(rep(!vid.hc[STRIPE_LOG2]));
                end
                MODE_CHECKER: begin
                    red_n   = COLOR_W'(rep(vid.hc[STRIPE_LOG2] ^ vid.vc[STRIPE_LOG2]));
                    green_n = red_n;
                    blue_n  = red_n;
                end
                MODE_BARS: begin
                    red_n   = COLOR_W'(rep(bar[2]));
                    green_n = COLOR_W'(rep(bar[1]));
                    blue_n  = COLOR_W'(rep(bar[0]));
                end
                MODE_SCROLL: begin
                    red_n   = COLOR_W'(rep(scroll_vc[STRIPE_LOG2]));
                    green_n = COLOR_W'(rep(!scroll_vc[STRIPE_LOG2]));
                end
                MODE_SOLID: begin
                    {red_n, green_n, blue_n} = solid_q;
                end
                default: begin
                    red_n   = '0;
                    green_n = '0;
                    blue_n  = '0;
                end
            endcase
        end
    end

    // Output register: colour and video enable stay aligned one clock late.
    always_ff @(posedge clk) begin
        if (rst) begin
            vid.red     <= '0;
            vid.green   <= '0;
            vid.blue    <= '0;
            vid.vidon_o <= 1'b0;
        end else begin
            vid.red     <= red_n;
            vid.green   <= green_n;
            vid.blue    <= blue_n;
            vid.vidon_o <= vid.vidon;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed self-checking bench for vga_pattern_gen. Each step drives one
// pixel and checks the registered result one clock later.
module tb_vga_pattern_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  mode = 3'd3;
    logic        pause = 1'b0;
    logic [11:0] solid_rgb = 12'h000;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;

    vga_pattern_gen_if #(.COLOR_W(4), .COORD_W(11)) vif ();

    vga_pattern_gen dut (
        .clk        (clk),
        .rst        (rst),
        .vid        (vif),
        .mode       (mode),
        .pause      (pause),
        .solid_rgb  (solid_rgb),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] px(input logic [3:0] r, input logic [3:0] g,
                                       input logic [3:0] b, input logic vo);
        return {r, g, b, 3'b000, vo};
    endfunction

    // Drive one pixel, clock it in, and settle just after the edge.
    task automatic applyStimulus(input logic von, input int h, input int v);
        vif.vidon = von;
        vif.hc    = 11'(h);
        vif.vc    = 11'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] expected);
        logic [15:0] observed;
        observed = {vif.red, vif.green, vif.blue, 3'b000, vif.vidon_o};
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s rgb_vo observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkTick(input string tag, input logic expected);
        total++;
        assert (frame_tick === expected) else begin
            bad++;
            $error("[TB] FAIL %s frame_tick observed=%b expected=%b", tag, frame_tick, expected);
        end
    endtask

    // Short synthetic frame: one non-zero line then line 0 (tick on the second step).
    task automatic runFrames(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 0, 1);
            applyStimulus(1'b0, 0, 0);
        end
    endtask

    initial begin
        vif.vidon = 1'b0;
        vif.hc    = '0;
        vif.vc    = '0;

        // Reset mid-line with video on and bars requested.
        rst = 1'b1;
        mode = 3'd3;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 300 + i, 200);
        checkOutput("reset_rgb", px(4'h0, 4'h0, 4'h0, 1'b0));
        checkTick("reset_tick", 1'b0);
        rst = 1'b0;
        applyStimulus(1'b1, 301, 200);
        checkOutput("post_reset_hstripe", px(4'h0, 4'hF, 4'h0, 1'b1));
        checkTick("post_reset_no_tick", 1'b0);
        applyStimulus(1'b1, 0, 523);
        applyStimulus(1'b1, 0, 524);
        checkTick("no_tick_524", 1'b0);
        applyStimulus(1'b1, 0, 0);
        checkTick("tick_wrap", 1'b1);
        checkOutput("tick_uses_old_mode", px(4'h0, 4'hF, 4'h0, 1'b1));
        applyStimulus(1'b1, 1, 0);
        checkTick("tick_one_cycle", 1'b0);
        checkOutput("bars_latched", px(4'h0, 4'h0, 4'h0, 1'b1));

        // Horizontal stripes.
        mode = 3'd0;
        runFrames(1);
        applyStimulus(1'b1, 5, 16);
        checkOutput("hstripe_vc16", px(4'hF, 4'h0, 4'h0, 1'b1));
        applyStimulus(1'b1, 5, 15);
        checkOutput("hstripe_vc15", px(4'h0, 4'hF, 4'h0, 1'b1));
        applyStimulus(1'b0, 5, 16);
        checkOutput("hstripe_blank", px(4'h0, 4'h0, 4'h0, 1'b0));

        // Mid-frame mode change waits for the frame tick.
        mode = 3'd2;
        applyStimulus(1'b1, 16, 100);
        checkOutput("mode_held_vc100", px(4'h0, 4'hF, 4'h0, 1'b1));
        applyStimulus(1'b1, 16, 524);
        checkOutput("mode_held_vc524", px(4'h0, 4'hF, 4'h0, 1'b1));
        applyStimulus(1'b1, 0, 0);
        checkTick("checker_tick", 1'b1);
        applyStimulus(1'b1, 16, 0);
        checkOutput("checker_16_0", px(4'hF, 4'hF, 4'hF, 1'b1));
        applyStimulus(1'b1, 16, 16);
        checkOutput("checker_16_16", px(4'h0, 4'h0, 4'h0, 1'b1));

        // Colour bars, including edges and saturation.
        mode = 3'd3;
        runFrames(1);
        applyStimulus(1'b1, 0, 10);
        checkOutput("bars_hc0", px(4'h0, 4'h0, 4'h0, 1'b1));
        applyStimulus(1'b1, 79, 10);
        checkOutput("bars_hc79", px(4'h0, 4'h0, 4'h0, 1'b1));
        applyStimulus(1'b1, 80, 10);
        checkOutput("bars_hc80", px(4'h0, 4'h0, 4'hF, 1'b1));
        applyStimulus(1'b1, 320, 10);
        checkOutput("bars_hc320", px(4'hF, 4'h0, 4'h0, 1'b1));
        applyStimulus(1'b1, 559, 10);
        checkOutput("bars_hc559", px(4'hF, 4'hF, 4'h0, 1'b1));
        applyStimulus(1'b1, 639, 10);
        checkOutput("bars_hc639", px(4'hF, 4'hF, 4'hF, 1'b1));
        applyStimulus(1'b1, 700, 10);
        checkOutput("bars_hc700", px(4'hF, 4'hF, 4'hF, 1'b1));

        // Vertical stripes.
        mode = 3'd1;
        runFrames(1);
        applyStimulus(1'b1, 16, 0);
        checkOutput("vstripe_hc16", px(4'hF, 4'h0, 4'h0, 1'b1));
        applyStimulus(1'b1, 15, 0);
        checkOutput("vstripe_hc15", px(4'h0, 4'hF, 4'h0, 1'b1));

        // Scrolling from a clean offset of 0.
        rst = 1'b1;
        applyStimulus(1'b0, 0, 0);
        rst = 1'b0;
        mode = 3'd4;
        runFrames(6);
        applyStimulus(1'b1, 0, 13);
        checkOutput("scroll_off3_vc13", px(4'hF, 4'h0, 4'h0, 1'b1));
        applyStimulus(1'b1, 0, 12);
        checkOutput("scroll_off3_vc12", px(4'h0, 4'hF, 4'h0, 1'b1));
        pause = 1'b1;
        runFrames(4);
        applyStimulus(1'b1, 0, 12);
        checkOutput("pause_vc12", px(4'h0, 4'hF, 4'h0, 1'b1));
        applyStimulus(1'b1, 0, 13);
        checkOutput("pause_vc13", px(4'hF, 4'h0, 4'h0, 1'b1));
        pause = 1'b0;
        runFrames(1);
        applyStimulus(1'b1, 0, 12);
        checkOutput("unpause_div_only", px(4'h0, 4'hF, 4'h0, 1'b1));
        // 1 + 2*2043 more frames lifts the offset from 3 to 2047.
        runFrames(1 + 2 * 2043);
        applyStimulus(1'b1, 0, 16);
        checkOutput("scroll_off2047_vc16", px(4'h0, 4'hF, 4'h0, 1'b1));
        applyStimulus(1'b1, 0, 17);
        checkOutput("scroll_off2047_vc17", px(4'hF, 4'h0, 4'h0, 1'b1));
        runFrames(2);
        applyStimulus(1'b1, 0, 16);
        checkOutput("scroll_wrap_vc16", px(4'hF, 4'h0, 4'h0, 1'b1));
        applyStimulus(1'b1, 0, 15);
        checkOutput("scroll_wrap_vc15", px(4'h0, 4'hF, 4'h0, 1'b1));

        // Solid colour latched at the frame tick only.
        mode = 3'd5;
        solid_rgb = 12'hA5C;
        runFrames(1);
        applyStimulus(1'b1, 3, 5);
        checkOutput("solid_A5C", px(4'hA, 4'h5, 4'hC, 1'b1));
        solid_rgb = 12'h123;
        applyStimulus(1'b1, 4, 5);
        checkOutput("solid_held", px(4'hA, 4'h5, 4'hC, 1'b1));
        applyStimulus(1'b1, 4, 524);
        checkTick("solid_no_tick", 1'b0);
        applyStimulus(1'b1, 0, 0);
        checkTick("solid_tick", 1'b1);
        checkOutput("solid_tick_old", px(4'hA, 4'h5, 4'hC, 1'b1));
        applyStimulus(1'b1, 1, 0);
        checkTick("solid_tick_drop", 1'b0);
        checkOutput("solid_123", px(4'h1, 4'h2, 4'h3, 1'b1));
        applyStimulus(1'b0, 1, 0);
        checkOutput("solid_blank", px(4'h0, 4'h0, 4'h0, 1'b0));

        // Unused mode is black.
        mode = 3'd6;
        runFrames(1);
        applyStimulus(1'b1, 16, 16);
        checkOutput("mode6_black", px(4'h0, 4'h0, 4'h0, 1'b1));

        // Reset exit with vc held at 0 must not tick.
        rst = 1'b1;
        applyStimulus(1'b1, 5, 0);
        checkOutput("reset2_rgb", px(4'h0, 4'h0, 4'h0, 1'b0));
        rst = 1'b0;
        applyStimulus(1'b1, 6, 0);
        checkTick("reset2_no_tick", 1'b0);
        checkOutput("reset2_hstripe", px(4'h0, 4'hF, 4'h0, 1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
